mult_shift_add: RTL and testbench

Sequential 32x32 signed multiplier for the multdiv unit. It consumes the ALU operand buses and produces a 32-bit product, an overflow exception and a one-cycle ready strobe. Partial products come from the 32-bit bitwise-AND stage: the multiplicand ANDed with the replicated current multiplier bit. Each partial product is accumulated, one bit per clock, over 32 cycles.

---
 rtl/mult_shift_add.sv | 109 ++++++++++
 tb/tb_mult_shift_add.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mult_shift_add.sv
// Sequential 32x32 signed shift-and-add multiplier: one partial product per clock,
// with the sign-bit iteration subtracted so the accumulator holds the exact 64-bit product.
module mult_shift_add #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int unsigned AccW = 2 * WIDTH;
  localparam int unsigned IdxW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [IdxW-1:0]  idx;
  logic             last;
  logic [WIDTH-1:0] pp;
  logic [AccW-1:0]  pp_sh;
  logic [AccW-1:0]  acc_step;
  logic [WIDTH:0]   acc_hi;

  always_comb begin
    idx      = cnt_q[IdxW-1:0];
    last     = (idx == IdxW'(WIDTH - 1));
    pp       = a_q & {WIDTH{b_q[idx]}};
    pp_sh    = {{WIDTH{pp[WIDTH-1]}}, pp} << idx;
    // The multiplier's sign bit carries weight -2^(WIDTH-1), hence the subtraction.
    acc_step = last ? (acc_q - pp_sh) : (acc_q + pp_sh);
    acc_hi   = acc_step[AccW-1:WIDTH-1];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    if (ctrl_MULT) begin
      // A start in any state recaptures and aborts whatever was in flight.
      a_d     = data_operandA;
      b_d     = data_operandB;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = StRun;
    end else begin
      case (state_q)
        StIdle: state_d = StIdle;
        StRun: begin
          acc_d = acc_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            state_d  = StDone;
            result_d = acc_step[WIDTH-1:0];
            exc_d    = !((acc_hi == '0) || (acc_hi == '1));
            rdy_d    = 1'b1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_mult_shift_add.sv
// Bench for mult_shift_add: directed and random products against a 64-bit arithmetic model.
module tb_mult_shift_add;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int total = 0;
  int bad   = 0;

  mult_shift_add #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_MULT     (ctrl_MULT),
    .data_operandA (opa),
    .data_operandB (opb),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  function automatic longint prod(input logic [31:0] x, input logic [31:0] y);
    return longint'($signed(x)) * longint'($signed(y));
  endfunction

  function automatic logic ovf(input longint p);
    return (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just before a rising edge (at a falling edge); that edge samples the start.
  task automatic start(input logic [31:0] x, input logic [31:0] y);
    opa       = x;
    opb       = y;
    ctrl_MULT = 1'b1;
    @(posedge clock);
  endtask

  // Returns at the falling edge where RDY is first seen; k = rising edges after the start edge.
  task automatic wait_rdy(input bit scramble, output int k);
    k = 0;
    while (1) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      if (scramble) begin
        opa = $urandom;
        opb = $urandom;
      end
      if (data_resultRDY || k > 40) break;
      @(posedge clock);
      k++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] x, input logic [31:0] y,
                              input int k);
    longint p;
    p = prod(x, y);
    check({tag, "_latency"}, 32'(k), 32'd32);
    check({tag, "_result"}, data_result, p[31:0]);
    check({tag, "_exc"}, {31'b0, data_exception}, {31'b0, ovf(p)});
  endtask

  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input bit scramble);
    int k;
    @(negedge clock);
    start(x, y);
    wait_rdy(scramble, k);
    check_result(tag, x, y, k);
    @(negedge clock);
    check({tag, "_rdy_drop"}, {31'b0, data_resultRDY}, 32'd0);
    check({tag, "_hold"}, data_result, 32'(prod(x, y)));
  endtask

  logic [31:0] dir_a [6] = '{32'd3, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h7FFFFFFF,
                             32'h80000000, 32'h80000000};
  logic [31:0] dir_b [6] = '{32'd4, 32'd6, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd1};

  initial begin
    int k;
    logic [31:0] x1, y1, x2, y2;

    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_exc", {31'b0, data_exception}, 32'd0);
    check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Directed products, including the overflow boundaries.
    for (int i = 0; i < 6; i++) run($sformatf("dir%0d", i), dir_a[i], dir_b[i], 1'b0);
    check("basic_literal", 32'(prod(32'd3, 32'd4)), 32'h0000000C);

    // Bus changes during the run must be ignored.
    run("stable", 32'd5, 32'd5, 1'b1);

    // Restart at E10: no RDY for the aborted op, single RDY 32 edges after the restart.
    @(negedge clock);
    start(32'd5, 32'd5);
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      check("restart_nordy", {31'b0, data_resultRDY}, 32'd0);
      @(posedge clock);
    end
    @(negedge clock);
    start(32'd2, 32'd9);
    wait_rdy(1'b0, k);
    check_result("restart", 32'd2, 32'd9, k);

    // Reset asserted at E15 clears outputs at once and kills the run.
    @(negedge clock);
    start(32'd100, 32'd100);
    repeat (15) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("midrst_result", data_result, 32'd0);
    check("midrst_exc", {31'b0, data_exception}, 32'd0);
    check("midrst_rdy", {31'b0, data_resultRDY}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      check("postrst_nordy", {31'b0, data_resultRDY}, 32'd0);
    end
    run("after_rst", 32'd100, 32'd100, 1'b0);

    // Back-to-back: second start sampled in the DONE cycle.
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
    @(negedge clock);
    start(x1, y1);
    wait_rdy(1'b0, k);
    check_result("b2b_first", x1, y1, k);
    start(x2, y2);
    wait_rdy(1'b0, k);
    check_result("b2b_second", x2, y2, k);

    // Start held high: nothing ever completes.
    @(negedge clock);
    ctrl_MULT = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      opa = $urandom;
      opb = $urandom;
      check("held_nordy", {31'b0, data_resultRDY}, 32'd0);
    end
    ctrl_MULT = 1'b0;

    // Random operands, mixing small and full-width values.
    for (int i = 0; i < 20; i++) begin
      x1 = (i % 3 == 0) ? 32'($signed(16'($urandom))) : $urandom;
      y1 = (i % 2 == 0) ? 32'($signed(16'($urandom))) : $urandom;
      run($sformatf("rnd%0d", i), x1, y1, i[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
